// File: rtl/dcache_traffic_checker.sv
// CPU-side traffic generator and checker for the data cache bench: writes an address-derived
// pattern over WAYS x SETS lines, reads it back, then reads one uncached line and compares.
module dcache_traffic_checker #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 1,
  parameter int unsigned WORDS      = 4,
  parameter logic [31:0] WAY_STRIDE = 32'h1000,
  parameter logic [31:0] MISS_BASE  = 32'h2000,
  parameter logic [31:0] SEED       = 32'h5A5A_C3C3,
  parameter bit          READBACK   = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stallreq_from_dcache,
  input  logic                 data_ok,
  input  logic [31:0]          dcache_data_i,
  input  logic [WORDS*32-1:0]  mem_line_i,
  output logic [31:0]          cpu_addr_o,
  output logic [31:0]          cpu_wdata_o,
  output logic                 cpu_wreq_o,
  output logic                 cpu_rreq_o,
  output logic [3:0]           cpu_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [15:0]          err_cnt_o,
  output logic [31:0]          err_addr_o
);

  localparam int KW = $clog2(WORDS);
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [KW-1:0] WORD_LAST = KW'(WORDS - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETS - 1);
  localparam logic [WW-1:0] WAY_LAST  = WW'(WAYS - 1);
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0]   LINE_BYTES = 32'(WORDS * 4);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_MISS_REQ, S_MISS_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   word_q;
  logic [SW-1:0]   set_q;
  logic [WW-1:0]   way_q;
  logic [7:0]      tmo_q;
  logic [15:0]     err_cnt_q;
  logic [31:0]     err_addr_q;

  logic            wreq, rreq, clr, step_all, step_k, check, tmo_ev, tmo_inc, tmo_clr;
  logic            last_word, last_all, miss_phase, err_ev;
  logic [31:0]     line_addr, miss_addr, cur_addr, pattern, exp_word;

  assign last_word  = (word_q == WORD_LAST);
  assign last_all   = last_word && (set_q == SET_LAST) && (way_q == WAY_LAST);
  assign miss_phase = (state_q == S_MISS_REQ) || (state_q == S_MISS_WAIT);

  // Addresses are derived from the counters, so nothing but the counters needs storing.
  assign line_addr = 32'(way_q) * WAY_STRIDE + 32'(set_q) * LINE_BYTES + 32'(word_q) * 32'd4;
  assign miss_addr = MISS_BASE + 32'(word_q) * 32'd4;
  assign cur_addr  = miss_phase ? miss_addr : line_addr;
  assign pattern   = {line_addr[15:0], ~line_addr[15:0]} ^ SEED;
  assign exp_word  = miss_phase ? mem_line_i[int'(word_q)*32 +: 32] : pattern;
  assign err_ev    = (check && (dcache_data_i != exp_word)) || tmo_ev;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    wreq     = 1'b0;
    rreq     = 1'b0;
    clr      = 1'b0;
    step_all = 1'b0;
    step_k   = 1'b0;
    check    = 1'b0;
    tmo_ev   = 1'b0;
    tmo_inc  = 1'b0;
    tmo_clr  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wreq = 1'b1;
        if (!stallreq_from_dcache) begin
          step_all = 1'b1;
          if (last_all) state_d = READBACK ? S_RD_REQ : S_MISS_REQ;
        end
      end
      S_RD_REQ: begin
        rreq = 1'b1;
        if (!stallreq_from_dcache) begin
          tmo_clr = 1'b1;
          // Data returned in the acceptance cycle is consumed right away.
          if (data_ok) begin
            check    = 1'b1;
            step_all = 1'b1;
            state_d  = last_all ? S_MISS_REQ : S_RD_REQ;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (data_ok || tmo_q == TMO_LAST) begin
          check    = data_ok;
          tmo_ev   = !data_ok;
          step_all = 1'b1;
          state_d  = last_all ? S_MISS_REQ : S_RD_REQ;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_MISS_REQ: begin
        rreq = 1'b1;
        if (!stallreq_from_dcache) begin
          tmo_clr = 1'b1;
          if (data_ok) begin
            check   = 1'b1;
            step_k  = 1'b1;
            state_d = last_word ? S_DONE : S_MISS_REQ;
          end else begin
            state_d = S_MISS_WAIT;
          end
        end
      end
      S_MISS_WAIT: begin
        if (data_ok || tmo_q == TMO_LAST) begin
          check   = data_ok;
          tmo_ev  = !data_ok;
          step_k  = 1'b1;
          state_d = last_word ? S_DONE : S_MISS_REQ;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      set_q  <= '0;
      way_q  <= '0;
    end else if (clr) begin
      word_q <= '0;
      set_q  <= '0;
      way_q  <= '0;
    end else if (step_all || step_k) begin
      word_q <= last_word ? '0 : word_q + KW'(1);
      if (step_all && last_word) begin
        set_q <= (set_q == SET_LAST) ? '0 : set_q + SW'(1);
        if (set_q == SET_LAST) way_q <= (way_q == WAY_LAST) ? '0 : way_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (clr || tmo_clr) begin
      tmo_q <= '0;
    end else if (tmo_inc) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (clr) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (err_ev) begin
      if (err_cnt_q == 16'h0)    err_addr_q <= cur_addr;
      if (err_cnt_q != 16'hFFFF) err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign cpu_wreq_o  = wreq;
  assign cpu_rreq_o  = rreq;
  assign cpu_addr_o  = (wreq || rreq) ? cur_addr : 32'h0;
  assign cpu_wdata_o = wreq ? pattern : 32'h0;
  assign cpu_sel_o   = (wreq || rreq) ? 4'hF : 4'h0;
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = done_o && (err_cnt_q == 16'h0);
  assign err_cnt_o   = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule
